// File: rtl/exec_pkg.sv
// exec_pkg: shared ALU operation codes and FSM state encoding for the execute stage.
package exec_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDU = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SUBU = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOR  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_SLL  = 4'd10;
    localparam logic [3:0] OP_SRL  = 4'd11;
    localparam logic [3:0] OP_SRA  = 4'd12;
    localparam logic [3:0] OP_LUI  = 4'd13;
    localparam logic [3:0] OP_MUL  = 4'd14;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL
    } state_t;

endpackage

// File: rtl/alu_comb.sv
// alu_comb: single-cycle combinational ALU.
// Ports: i_a, i_b operands; i_op operation code; i_shamt shift amount;
//        o_result WIDTH-bit result (0 for MUL/undefined); o_ovf signed overflow (ADD/SUB only).
module alu_comb
    import exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_op,
    input  logic [4:0]       i_shamt,
    output logic [WIDTH-1:0] o_result,
    output logic             o_ovf
);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_sa;
    logic             w_sb;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;
    assign w_sa   = i_a[WIDTH-1];
    assign w_sb   = i_b[WIDTH-1];

    always_comb begin
        o_result = '0;
        o_ovf    = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_result = w_sum;
                o_ovf    = (w_sa == w_sb) && (w_sum[WIDTH-1] != w_sa);
            end
            OP_ADDU: o_result = w_sum;
            OP_SUB: begin
                o_result = w_diff;
                o_ovf    = (w_sa != w_sb) && (w_diff[WIDTH-1] != w_sa);
            end
            OP_SUBU: o_result = w_diff;
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_NOR:  o_result = ~(i_a | i_b);
            OP_SLT:  o_result = WIDTH'($signed(i_a) < $signed(i_b));
            OP_SLTU: o_result = WIDTH'(i_a < i_b);
            OP_SLL:  o_result = i_b << i_shamt;
            OP_SRL:  o_result = i_b >> i_shamt;
            OP_SRA:  o_result = $signed(i_b) >>> i_shamt;
            OP_LUI:  o_result = WIDTH'(i_b[15:0]) << 16;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/exec_stage.sv
// exec_stage: multicycle execute stage; latches operands on start, runs the ALU op
// (or an iterative shift-add multiply) and registers the result.
// Ports: EX_clk/rst_n clock and async active-low reset; start request (IDLE only);
//        ALUctr op code; ALUSrc/ExtOp/imm16 select and extend the B operand; busA/busB
//        register-file operands; shamt shift amount; ALUOut/Zero/Overflow registered
//        results; busy (not IDLE); done one-cycle result-valid pulse.
module exec_stage
    import exec_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MUL_STEPS = 32
) (
    input  logic             EX_clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALUctr,
    input  logic             ALUSrc,
    input  logic             ExtOp,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    input  logic [15:0]      imm16,
    input  logic [4:0]       shamt,
    output logic [WIDTH-1:0] ALUOut,
    output logic             Zero,
    output logic             Overflow,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(MUL_STEPS + 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_op;
    logic [4:0]       r_shamt;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_out;
    logic             r_zero;
    logic             r_ovf;
    logic             r_done;
    logic [WIDTH-1:0] w_b_sel;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic [WIDTH-1:0] w_acc;
    logic             w_last;

    assign w_b_sel = ALUSrc ? {{(WIDTH-16){ExtOp & imm16[15]}}, imm16} : busB;
    // During MUL r_a is the multiplicand (shifted left) and r_b the multiplier (shifted right).
    assign w_acc   = r_acc + (r_b[0] ? r_a : '0);
    assign w_last  = r_cnt == CW'(MUL_STEPS - 1);

    alu_comb #(.WIDTH(WIDTH)) u_alu (
        .i_a     (r_a),
        .i_b     (r_b),
        .i_op    (r_op),
        .i_shamt (r_shamt),
        .o_result(w_res),
        .o_ovf   (w_ovf)
    );

    always_ff @(posedge EX_clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? (ALUctr == OP_MUL ? S_MUL : S_EXEC) : S_IDLE;
            S_EXEC:  w_next = S_IDLE;
            S_MUL:   w_next = w_last ? S_IDLE : S_MUL;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge EX_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_shamt <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_zero  <= 1'b1;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_a     <= busA;
                    r_b     <= w_b_sel;
                    r_op    <= ALUctr;
                    r_shamt <= shamt;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                end
                S_EXEC: begin
                    r_out  <= w_res;
                    r_zero <= w_res == '0;
                    r_ovf  <= w_ovf;
                    r_done <= 1'b1;
                end
                S_MUL: begin
                    r_acc <= w_acc;
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_out  <= w_acc;
                        r_zero <= w_acc == '0;
                        r_ovf  <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ALUOut   = r_out;
    assign Zero     = r_zero;
    assign Overflow = r_ovf;
    assign busy     = r_state != S_IDLE;
    assign done     = r_done;

endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: directed self-checking bench for exec_stage.
module tb_exec_stage;
    import exec_pkg::*;

    logic        EX_clk = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic [3:0]  ALUctr = '0;
    logic        ALUSrc = 1'b0;
    logic        ExtOp  = 1'b0;
    logic [31:0] busA   = '0;
    logic [31:0] busB   = '0;
    logic [15:0] imm16  = '0;
    logic [4:0]  shamt  = '0;
    logic [31:0] ALUOut;
    logic        Zero;
    logic        Overflow;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;
    int cnt;

    exec_stage #(.WIDTH(32), .MUL_STEPS(32)) dut (
        .EX_clk  (EX_clk),
        .rst_n   (rst_n),
        .start   (start),
        .ALUctr  (ALUctr),
        .ALUSrc  (ALUSrc),
        .ExtOp   (ExtOp),
        .busA    (busA),
        .busB    (busB),
        .imm16   (imm16),
        .shamt   (shamt),
        .ALUOut  (ALUOut),
        .Zero    (Zero),
        .Overflow(Overflow),
        .busy    (busy),
        .done    (done)
    );

    always #5 EX_clk = ~EX_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request; returns at the falling edge just after the latching edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic src, input logic ext, input logic [15:0] imm,
                         input logic [4:0] sh);
        @(negedge EX_clk);
        ALUctr = op; busA = a; busB = b; ALUSrc = src; ExtOp = ext; imm16 = imm; shamt = sh;
        start = 1'b1;
        @(negedge EX_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int c);
        c = 0;
        while (!done && c < 100) begin
            @(negedge EX_clk);
            c++;
        end
    endtask

    task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic src, input logic ext,
                          input logic [15:0] imm, input logic [4:0] sh,
                          input logic [31:0] exp_out, input logic exp_ovf);
        int c;
        issue(op, a, b, src, ext, imm, sh);
        wait_done(c);
        chk({tag, " latency"}, 32'(c), 32'd1);
        chk({tag, " ALUOut"}, ALUOut, exp_out);
        chk({tag, " Overflow"}, 32'(Overflow), 32'(exp_ovf));
        chk({tag, " Zero"}, 32'(Zero), 32'(exp_out == 32'd0));
        @(negedge EX_clk);
        chk({tag, " done width"}, 32'(done), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge EX_clk);
        chk("reset ALUOut", ALUOut, 32'd0);
        chk("reset Zero", 32'(Zero), 32'd1);
        chk("reset Overflow", 32'(Overflow), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        rst_n = 1'b1;

        single("ADD ovf", OP_ADD, 32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, 16'h0, 5'd0, 32'h80000000, 1'b1);
        single("ADDU", OP_ADDU, 32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, 16'h0, 5'd0, 32'h80000000, 1'b0);

        // Reset in the middle of a multiply: outputs clear at once, no done afterwards.
        issue(OP_MUL, 32'd7, 32'd9, 1'b0, 1'b0, 16'h0, 5'd0);
        repeat (9) @(negedge EX_clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midmul rst ALUOut", ALUOut, 32'd0);
        chk("midmul rst Zero", 32'(Zero), 32'd1);
        chk("midmul rst busy", 32'(busy), 32'd0);
        @(negedge EX_clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(negedge EX_clk);
            if (done) cnt++;
        end
        chk("midmul no done", 32'(cnt), 32'd0);

        single("SUB zero", OP_SUB, 32'd5, 32'd5, 1'b0, 1'b0, 16'h0, 5'd0, 32'd0, 1'b0);
        single("SUB ovf", OP_SUB, 32'h80000000, 32'd1, 1'b0, 1'b0, 16'h0, 5'd0, 32'h7FFFFFFF, 1'b1);
        single("SLT", OP_SLT, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 16'h0, 5'd0, 32'd1, 1'b0);
        single("SLTU", OP_SLTU, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 16'h0, 5'd0, 32'd0, 1'b0);
        single("ADD sext imm", OP_ADD, 32'd3, 32'hDEADBEEF, 1'b1, 1'b1, 16'hFFFF, 5'd0, 32'd2, 1'b0);
        single("OR zext imm", OP_OR, 32'd0, 32'hDEADBEEF, 1'b1, 1'b0, 16'hFFFF, 5'd0, 32'h0000FFFF, 1'b0);
        single("LUI", OP_LUI, 32'd0, 32'd0, 1'b1, 1'b0, 16'h1234, 5'd0, 32'h12340000, 1'b0);
        single("XOR", OP_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b0, 16'h0, 5'd0, 32'h0FF00FF0, 1'b0);
        single("NOR", OP_NOR, 32'hF0F0F0F0, 32'h0000FFFF, 1'b0, 1'b0, 16'h0, 5'd0, 32'h0F0F0000, 1'b0);
        single("SLL", OP_SLL, 32'd0, 32'd1, 1'b0, 1'b0, 16'h0, 5'd4, 32'd16, 1'b0);
        single("SRA", OP_SRA, 32'd0, 32'h80000000, 1'b0, 1'b0, 16'h0, 5'd31, 32'hFFFFFFFF, 1'b0);
        single("undef op", 4'd15, 32'd9, 32'd9, 1'b0, 1'b0, 16'h0, 5'd0, 32'd0, 1'b0);

        // Operands must be latched: busB changes right after the latching edge.
        issue(OP_SRL, 32'd0, 32'h80000000, 1'b0, 1'b0, 16'h0, 5'd31);
        busB = 32'd0;
        wait_done(cyc);
        chk("SRL latency", 32'(cyc), 32'd1);
        chk("SRL latched ALUOut", ALUOut, 32'd1);

        // Multiply with a stray start pulse in the middle.
        issue(OP_MUL, 32'd12345, 32'd678, 1'b0, 1'b0, 16'h0, 5'd0);
        cyc = 0;
        cnt = 0;
        while (!done && cyc < 100) begin
            if (cyc == 10) begin
                start = 1'b1; ALUctr = OP_ADD; busA = 32'd1; busB = 32'd1;
            end
            if (cyc == 11) start = 1'b0;
            @(negedge EX_clk);
            cyc++;
            if (!done && !busy) cnt++;
        end
        chk("MUL latency", 32'(cyc), 32'd32);
        chk("MUL busy gaps", 32'(cnt), 32'd0);
        chk("MUL ALUOut", ALUOut, 32'd8369910);
        chk("MUL Overflow", 32'(Overflow), 32'd0);
        chk("MUL Zero", 32'(Zero), 32'd0);
        @(negedge EX_clk);
        chk("MUL done width", 32'(done), 32'd0);
        chk("MUL idle after", 32'(busy), 32'd0);
        chk("MUL result held", ALUOut, 32'd8369910);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
